// File: rtl/clk_div_gen.sv
// Runtime-reconfigurable divided-clock generator: NUM_CLKS phase-aligned outputs from refclk, with a lock indication.
// Optional macro CLKDIV_CE_EN adds registered per-channel clock-enable pulses (ce).
module clk_div_gen #(
  parameter int                         NUM_CLKS    = 2,
  parameter int                         DIV_W       = 8,
  parameter logic [NUM_CLKS*DIV_W-1:0]  DIV_INIT    = {8'd10, 8'd5},
  parameter int                         LOCK_CYCLES = 16
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [2:0]          cfg_sel,
  input  logic [DIV_W-1:0]    cfg_div,
  output logic [NUM_CLKS-1:0] outclk,
`ifdef CLKDIV_CE_EN
  output logic [NUM_CLKS-1:0] ce,
`endif
  output logic                locked
);

  localparam int               DW1       = DIV_W + 1;
  localparam int               LCW       = $clog2(LOCK_CYCLES + 1);
  localparam logic [LCW-1:0]   LOCK_LAST = LCW'(LOCK_CYCLES - 1);
  localparam logic [3:0]       NCLK4     = 4'(NUM_CLKS);

  typedef enum logic [1:0] {
    ALIGN     = 2'd0,
    WAIT_LOCK = 2'd1,
    LOCKED    = 2'd2
  } state_t;

  // Divisors 0 and 1 cannot produce a toggling clock, so they saturate to 2.
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(2)) ? DIV_W'(2) : d;
  endfunction

  function automatic logic [DIV_W-1:0] high_len(input logic [DIV_W-1:0] d);
    logic [DW1-1:0] s;
    s = {1'b0, eff_div(d)} + DW1'(1);
    return s[DW1-1:1];
  endfunction

  state_t               state, state_nxt;
  logic [LCW-1:0]       lock_cnt;
  logic                 accept, sel_ok, load, run_nxt;
  logic [DIV_W-1:0]     div     [NUM_CLKS];
  logic [DIV_W-1:0]     cnt     [NUM_CLKS];
  logic [DIV_W-1:0]     cnt_nxt [NUM_CLKS];
  logic [NUM_CLKS-1:0]  out_nxt;
  logic [NUM_CLKS-1:0]  ce_nxt;

  always_ff @(posedge refclk) begin
    if (rst) state <= ALIGN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = cfg_valid && cfg_ready;
    sel_ok    = ({1'b0, cfg_sel} < NCLK4);
    load      = 1'b0;
    case (state)
      ALIGN:     state_nxt = WAIT_LOCK;
      WAIT_LOCK: if (lock_cnt == LOCK_LAST) state_nxt = LOCKED;
      LOCKED: begin
        if (accept && sel_ok) begin
          load      = 1'b1;
          state_nxt = ALIGN;
        end
      end
      default:   state_nxt = ALIGN;
    endcase
    run_nxt = (state_nxt != ALIGN);
  end

  // Counters restart together on leaving ALIGN, which is what keeps all channels phase-aligned.
  always_comb begin
    for (int i = 0; i < NUM_CLKS; i++) begin
      cnt_nxt[i] = '0;
      if ((state != ALIGN) && run_nxt && (cnt[i] < (eff_div(div[i]) - DIV_W'(1))))
        cnt_nxt[i] = cnt[i] + DIV_W'(1);
      out_nxt[i] = run_nxt && (cnt_nxt[i] < high_len(div[i]));
      ce_nxt[i]  = run_nxt && (cnt_nxt[i] == '0);
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_cnt  <= '0;
      locked    <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      lock_cnt  <= ((state == WAIT_LOCK) && (state_nxt == WAIT_LOCK)) ? lock_cnt + LCW'(1) : '0;
      locked    <= (state_nxt == LOCKED);
      cfg_ready <= (state_nxt == LOCKED);
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLKS; i++) div[i] <= DIV_INIT[i*DIV_W +: DIV_W];
    end else if (load) begin
      for (int i = 0; i < NUM_CLKS; i++)
        if (cfg_sel == 3'(i)) div[i] <= cfg_div;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLKS; i++) cnt[i] <= '0;
      outclk <= '0;
    end else begin
      for (int i = 0; i < NUM_CLKS; i++) cnt[i] <= cnt_nxt[i];
      outclk <= out_nxt;
    end
  end

`ifdef CLKDIV_CE_EN
  always_ff @(posedge refclk) begin
    if (rst) ce <= '0;
    else     ce <= ce_nxt;
  end
`else
  logic ce_unused;
  assign ce_unused = ^ce_nxt;
`endif

endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen: an arithmetic reference model predicts each cycle's outputs, a monitor compares.
`timescale 1ns/1ps
module tb_clk_div_gen;
  localparam int NCH  = 2;
  localparam int LOCK = 16;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [2:0] cfg_sel = 3'd0;
  logic [7:0] cfg_div = 8'd0;
  logic       cfg_ready, locked;
  logic [1:0] outclk;
`ifdef CLKDIV_CE_EN
  logic [1:0] ce;
`endif

  clk_div_gen #(
    .NUM_CLKS(2), .DIV_W(8), .DIV_INIT({8'd10, 8'd5}), .LOCK_CYCLES(LOCK)
  ) dut (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_sel(cfg_sel), .cfg_div(cfg_div), .outclk(outclk),
`ifdef CLKDIV_CE_EN
    .ce(ce),
`endif
    .locked(locked)
  );

  always #5 refclk = ~refclk;

  typedef struct packed {
    logic [1:0] oc;
    logic [1:0] ce;
    logic       lk;
    logic       rd;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: outputs follow from elapsed edges since alignment, modulo the effective divisor.
  bit   m_align  = 1'b1;
  bit   m_locked = 1'b0;
  int   m_start  = 0;
  int   m_div[NCH] = '{5, 10};
  int   edge_n   = 0;
  bit   hs       = 1'b0;

  task automatic model_edge();
    exp_t e;
    int   k, d;
    edge_n++;
    hs = 1'b0;
    if (rst) begin
      m_align  = 1'b1;
      m_locked = 1'b0;
      m_div[0] = 5;
      m_div[1] = 10;
    end else if (m_align) begin
      m_align = 1'b0;
      m_start = edge_n;
    end else if (m_locked) begin
      if (cfg_valid) begin
        hs = 1'b1;
        if (int'(cfg_sel) < NCH) begin
          m_div[cfg_sel] = int'(cfg_div);
          m_align  = 1'b1;
          m_locked = 1'b0;
        end
      end
    end else if (edge_n - m_start == LOCK) begin
      m_locked = 1'b1;
    end
    e = '0;
    if (!m_align) begin
      k = edge_n - m_start;
      for (int i = 0; i < NCH; i++) begin
        d = (m_div[i] < 2) ? 2 : m_div[i];
        e.oc[i] = ((k % d) < ((d + 1) / 2));
        e.ce[i] = ((k % d) == 0);
      end
      e.lk = m_locked;
      e.rd = m_locked;
    end
    expq.push_back(e);
  endtask

  task automatic step();
    @(posedge refclk);
    model_edge();
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic req(input logic [2:0] s, input logic [7:0] dv);
    int waitc;
    waitc     = 0;
    cfg_valid = 1'b1;
    cfg_sel   = s;
    cfg_div   = dv;
    do begin
      step();
      waitc++;
    end while (!hs && waitc < 200);
    if (!hs) begin
      $display("FAIL cfg_handshake: not accepted after %0d cycles, required acceptance", waitc);
      n_bad++;
    end
    cfg_valid = 1'b0;
  endtask

  function automatic void chk(input string nm, input logic [1:0] act, input logic [1:0] req_v);
    n_cmp++;
    if (act !== req_v) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %b, expected %b", nm, $time, act, req_v);
    end
  endfunction

  always @(negedge refclk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("outclk", outclk, e.oc);
      chk("locked", {1'b0, locked}, {1'b0, e.lk});
      chk("cfg_ready", {1'b0, cfg_ready}, {1'b0, e.rd});
`ifdef CLKDIV_CE_EN
      chk("ce", ce, e.ce);
`endif
    end
  end

  initial begin
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(40);
    // Reprogram channel 1 to 4 while locked.
    req(3'd1, 8'd4);
    run(30);
    // Degenerate divisors on channel 0.
    req(3'd0, 8'd0);
    run(25);
    req(3'd0, 8'd1);
    run(25);
    // Out-of-range channel is consumed without disturbing anything.
    req(3'd5, 8'd7);
    run(20);
    // Request held through ALIGN/WAIT_LOCK is taken on the first locked cycle.
    req(3'd0, 8'd3);
    req(3'd1, 8'd6);
    run(25);
    // Reset in WAIT_LOCK after reprogramming restores defaults.
    req(3'd1, 8'd4);
    run(6);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(40);
    // Rewriting the current divisor still realigns.
    req(3'd0, 8'd5);
    run(25);
    // Randomised traffic.
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 149) == 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_sel   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
      cfg_div   = 8'($urandom_range(0, 12));
      step();
    end
    rst       = 1'b0;
    cfg_valid = 1'b0;
    run(3);
    for (int w = 0; w < 10 && expq.size() > 0; w++) @(negedge refclk);
    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
